// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath select/ALU operation codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RS_ALUOUT    = 2'b00;
  localparam logic [1:0] RS_DATA      = 2'b01;
  localparam logic [1:0] RS_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [6:0] o);
    return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_R) ||
           (o == OP_IMM) || (o == OP_BRANCH) || (o == OP_JAL) ||
           (o == OP_LUI);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's coarse ALUOp plus the instruction's funct fields
// onto a concrete ALU operation.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  // funct3 000 is sub only for R-type (op5 set) with funct7[5]; addi never subtracts.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_DECODE: begin
        case (funct3)
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b100:  ALUControl = ALU_XOR;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. One state per cycle;
// memory states wait on MemReady. Outputs are Moore-decoded from state
// except PCWrite/IRWrite (MemReady, Zero), ALUControl (funct fields) and
// Illegal (op). Handshake: a memory access is presented while the FSM sits
// in FETCH/MEMREAD/MEMWRITE and completes on the cycle MemReady is 1; the
// request is held unchanged until then. dbg_state exposes the FSM state.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output state_t     dbg_state
);

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;

  assign dbg_state = state;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic; memory states hold until MemReady.
  always_comb begin
    state_next = state;
    if (rst) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH:    state_next = MemReady ? DECODE : FETCH;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_next = MEMADR;
            OP_R:              state_next = EXECR;
            OP_IMM:            state_next = EXECI;
            OP_BRANCH:         state_next = BRANCH;
            OP_JAL:            state_next = JAL;
            OP_LUI:            state_next = LUI;
            default:           state_next = FETCH;
          endcase
        end
        MEMADR:   state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  state_next = MemReady ? MEMWB : MEMREAD;
        MEMWRITE: state_next = MemReady ? FETCH : MEMWRITE;
        MEMWB:    state_next = FETCH;
        EXECR, EXECI, JAL, LUI: state_next = ALUWB;
        ALUWB:    state_next = FETCH;
        BRANCH:   state_next = FETCH;
        default:  state_next = FETCH;
      endcase
    end
  end

  // Output decode; reset masks every enable so an aborted access never writes.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RS_ALURESULT;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        Illegal = !op_supported(op);
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RS_ALUOUT;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RS_ALUOUT;
        MemWrite  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RS_DATA;
        RegWrite  = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_DECODE;
      end
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        alu_op  = ALUOP_DECODE;
      end
      ALUWB: begin
        ResultSrc = RS_ALUOUT;
        RegWrite  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RS_ALUOUT;
        // beq takes on Zero, bne on !Zero; other compares are not supported.
        PCWrite   = (funct3[2:1] == 2'b00) ? (Zero ^ funct3[0]) : 1'b0;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RS_ALUOUT;
        ImmSrc    = IMM_J;
        PCWrite   = 1'b1;
      end
      LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per instruction, a reference model lists the
// expected cycles (state plus all outputs) from the instruction class,
// stall counts and Zero; a driver replays them and compares every cycle.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int W = 24;  // {state[3:0], MemReady, Zero, outs[17:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  state_t     dbg_state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0]   cur_op;
  logic [2:0]   cur_f3;
  logic         cur_f7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output vector order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl Illegal
  function automatic logic [17:0] outs(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALUControl, Illegal};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic pick_z(input int zmode);
    return (zmode == 2) ? rbit() : 1'(zmode);
  endfunction

  // ALU operation named by the instruction semantics.
  function automatic logic [2:0] alu_for(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;  // sub : add/addi
      3'd4:    return 3'b100;                          // xor
      3'd2:    return 3'b101;                          // slt
      3'd6:    return 3'b011;                          // or
      3'd7:    return 3'b010;                          // and
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic legal_op(input logic [6:0] o);
    logic [6:0] ok[7];
    ok = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37};
    foreach (ok[i]) if (o == ok[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input state_t st, input logic mr, input logic z, input logic [17:0] o);
    exp_q.push_back({st, mr, z, o});
  endtask

  // ---------------- reference model ----------------
  task automatic build(input logic [31:0] instr, input int fst, input int mst, input int zmode);
    logic taken, z;
    logic [17:0] wb;
    cur_op = instr[6:0];
    cur_f3 = instr[14:12];
    cur_f7 = instr[30];
    wb = outs(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    for (int i = 0; i < fst; i++)
      push(FETCH, 0, pick_z(zmode), outs(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    push(FETCH, 1, pick_z(zmode), outs(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    push(DECODE, rbit(), pick_z(zmode),
         outs(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, !legal_op(cur_op)));
    case (cur_op)
      7'h03: begin  // lw
        push(MEMADR, rbit(), pick_z(zmode), outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        for (int i = 0; i < mst; i++)
          push(MEMREAD, 0, pick_z(zmode), outs(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        push(MEMREAD, 1, pick_z(zmode), outs(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        push(MEMWB, rbit(), pick_z(zmode), outs(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      end
      7'h23: begin  // sw
        push(MEMADR, rbit(), pick_z(zmode), outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
        for (int i = 0; i < mst; i++)
          push(MEMWRITE, 0, pick_z(zmode), outs(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        push(MEMWRITE, 1, pick_z(zmode), outs(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      end
      7'h33: begin  // R-type
        push(EXECR, rbit(), pick_z(zmode),
             outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu_for(1, cur_f3, cur_f7), 0));
        push(ALUWB, rbit(), pick_z(zmode), wb);
      end
      7'h13: begin  // OP-IMM
        push(EXECI, rbit(), pick_z(zmode),
             outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu_for(0, cur_f3, cur_f7), 0));
        push(ALUWB, rbit(), pick_z(zmode), wb);
      end
      7'h63: begin  // branch: beq takes when equal, bne when not equal
        z = pick_z(zmode);
        taken = (cur_f3 == 3'd0 && z) || (cur_f3 == 3'd1 && !z);
        push(BRANCH, rbit(), z, outs(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
      end
      7'h6F: begin  // jal
        push(JAL, rbit(), pick_z(zmode), outs(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 0));
        push(ALUWB, rbit(), pick_z(zmode), wb);
      end
      7'h37: begin  // lui
        push(LUI, rbit(), pick_z(zmode), outs(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 0));
        push(ALUWB, rbit(), pick_z(zmode), wb);
      end
      default: ;  // illegal: straight back to fetch
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_one();
    logic [W-1:0] r;
    r = exp_q.pop_front();
    @(posedge clk);
    #1;
    op       = cur_op;
    funct3   = cur_f3;
    funct7b5 = cur_f7;
    MemReady = r[19];
    Zero     = r[18];
    @(negedge clk);
    check($sformatf("state op=%h", cur_op), 32'(dbg_state), 32'(r[23:20]));
    check($sformatf("outs op=%h st=%0d", cur_op, r[23:20]), 32'(dut_outs()), 32'(r[17:0]));
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fst, input int mst, input int zmode);
    build(instr, fst, mst, zmode);
    while (exp_q.size() > 0) drive_one();
  endtask

  task automatic run_partial(input logic [31:0] instr, input int fst, input int mst, input int n);
    build(instr, fst, mst, 2);
    repeat (n) drive_one();
    exp_q.delete();
  endtask

  // Reset for n cycles (n >= 2 so it is sampled on an edge), MemReady high
  // so a reset that fails to mask would show an enable.
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst      = 1'b1;
      MemReady = 1'b1;
      Zero     = rbit();
      @(negedge clk);
      check("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite, Illegal}), 32'd0);
      if (i > 0) check("reset_state", 32'(dbg_state), 32'(FETCH));
    end
    rst      = 1'b0;
    MemReady = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  kinds[8];
    logic [6:0]  o;
    w = $urandom;
    kinds = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37, 7'h00};
    o = kinds[$urandom_range(0, 7)];
    if (o == 7'h00) begin
      o = 7'($urandom);
      while (legal_op(o)) o = 7'($urandom);
    end
    return {w[31:7], o};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset_cycles(3);
    run_instr(32'h00402083, 0, 0, 2);   // lw x1,4(x0)
    run_instr(32'h402081B3, 0, 0, 2);   // sub
    run_instr(32'h002081B3, 0, 0, 2);   // add
    run_instr(32'h00209463, 0, 0, 0);   // bne, Zero=0 -> taken
    run_instr(32'h00209463, 0, 0, 1);   // bne, Zero=1 -> not taken
    run_instr(32'h00208463, 0, 0, 1);   // beq, Zero=1 -> taken
    run_instr(32'h0020A223, 3, 3, 2);   // sw with 3+3 wait cycles
    run_instr(32'h00008067, 0, 0, 2);   // jalr -> illegal
    run_instr(32'h00C0006F, 0, 0, 2);   // jal
    run_instr(32'h123450B7, 0, 0, 2);   // lui
    run_partial(32'h00402083, 0, 2, 4); // lw into MEMREAD wait, then reset
    reset_cycles(2);
    run_instr(32'h002081B3, 0, 0, 2);
    run_partial(32'h0020A223, 0, 2, 4); // sw into MEMWRITE wait, then reset
    reset_cycles(2);
    run_instr(32'h00402083, 1, 1, 2);
    for (int k = 0; k < 400; k++) begin
      run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC register, unified instruction/data memory, instruction register, register file, single ALU) through the fetch, decode, execute, memory and writeback steps, one state per cycle. It waits on memory through a ready handshake and produces all datapath select and write-enable signals.

## Interface
Parameters:
- none; all encodings come from `rv_ctrl_pkg`.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `op` in 7: `instr[6:0]` from the IR.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory has completed the current access.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: IR and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = A (rs1), 11 = zero.
- `ALUSrcB` out 2: ALU B select; 00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 3: immediate format; 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `Illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI.

Transitions:
- FETCH → DECODE when `MemReady`; otherwise stay in FETCH.
- DECODE dispatches on `op`:
  - lw/sw → MEMADR
  - R-type → EXECR
  - OP-IMM → EXECI
  - BRANCH → BRANCH
  - jal → JAL
  - lui → LUI
  - anything else (including jalr) → FETCH, with `Illegal` = 1.
- MEMADR → MEMREAD for lw, MEMWRITE for sw.
- MEMREAD → MEMWB when `MemReady`; otherwise hold.
- MEMWRITE → FETCH when `MemReady`; otherwise hold.
- MEMWB → FETCH.
- EXECR, EXECI, JAL, LUI → ALUWB.
- ALUWB → FETCH.
- BRANCH → FETCH.

Per-state outputs (unlisted enables are 0, unlisted selects are don't-care driven as 0):
- FETCH: `AdrSrc`=0; `IRWrite`=`MemReady`; `PCWrite`=`MemReady`; `ALUSrcA`=00, `ALUSrcB`=10, add; `ResultSrc`=10.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, add, `ImmSrc`=010 (branch target into ALUOut).
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add; `ImmSrc`=000 for lw, 001 for sw.
- MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
- MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1, held until `MemReady`.
- MEMWB: `ResultSrc`=01, `RegWrite`=1.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, ALU decode.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=000, ALU decode.
- ALUWB: `ResultSrc`=00, `RegWrite`=1.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00; `PCWrite` = `Zero` XOR `funct3[0]` (beq/bne only; other funct3 give `PCWrite`=0).
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `ImmSrc`=011, `PCWrite`=1.
- LUI: `ALUSrcA`=11, `ALUSrcB`=01, add, `ImmSrc`=100.

ALU decode (EXECR/EXECI), by `funct3`:
- 000: sub if R-type and `funct7b5`, else add.
- 100: xor.
- 010: slt.
- 110: or.
- 111: and.
- Any other `funct3`: add, with no `Illegal` pulse.

## Timing
- Outputs are Moore-decoded from state, except the following, which are combinational on their inputs: `PCWrite` (depends on `Zero`/`MemReady`), `IRWrite` (`MemReady`), `ALUControl` (`funct3`/`funct7b5`), `Illegal` (`op`).
- Cycles per instruction with `MemReady` always 1: lw 5, sw 4, R/I/jal/lui 4, branch 3, illegal 2.
- Each cycle of `MemReady` low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset: while `rst`=1, next state is FETCH and every enable (`PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`) and `Illegal` is forced to 0. The first fetch begins in the cycle after `rst` deasserts.
- Reset mid-instruction, or mid-wait with `MemWrite` pending, aborts the access; no partial write enable is issued.
- `MemReady` is ignored in states that do not access memory.

## Structure
- `rv_ctrl_pkg` holds:
  - the `state_t` enum
  - opcode localparams (`OP_LOAD`, `OP_STORE`, `OP_R`, `OP_IMM`, `OP_BRANCH`, `OP_JAL`, `OP_LUI`)
  - the `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ImmSrc` and `ALUControl` encodings.
- Sub-module `alu_decoder` is combinational. Inputs: `ALUOp` (2 bits: 00 add, 01 sub, 10 decode), `funct3`, `op[5]`, `funct7b5`. Output: `ALUControl`.

## Test plan
- Reset held 3 cycles, then released: all enables are 0 during reset; the cycle after release is FETCH with `IRWrite`=`PCWrite`=1.
- Fetch `0x00402083` (lw x1,4(x0)) with `MemReady`=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `RegWrite`=1 only in cycle 5, with `ResultSrc`=01.
- `0x402081B3` (sub x3,x1,x2): `ALUControl`=001 in EXECR, `RegWrite` in ALUWB. `0x002081B3` (add) gives 000.
- `0x00209463` (bne x1,x2,8): with `Zero`=0, `PCWrite`=1 in BRANCH; with `Zero`=1, `PCWrite`=0. Back in FETCH at cycle 4.
- Hold `MemReady`=0 for 3 cycles in FETCH, then in MEMWRITE for sw `0x0020A223`: the state holds, `IRWrite`/`PCWrite` stay 0, `MemWrite` stays 1 throughout the wait, and the instruction completes in 4+6 = 10 cycles.
- Fetch `0x00008067` (jalr): `Illegal`=1 for one cycle in DECODE, then FETCH. Separately, assert `rst` during MEMREAD: no `RegWrite`, and the state is FETCH after release.
